// File: rtl/acc_register_file.sv
// Accumulator register file: general registers, a result register (res),
// and a LIFO save stack for res. All state changes on the falling clk edge.
module acc_register_file #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NREGS       = 8,
    parameter int unsigned STACK_DEPTH = 4,
    localparam int unsigned SEL_W      = $clog2(NREGS),
    localparam int unsigned CNT_W      = $clog2(STACK_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [SEL_W-1:0] reg_sel,
    input  logic [WIDTH-1:0] write_data,
    input  logic             err_clr,
    output logic [WIDTH-1:0] reg_val,
    output logic [WIDTH-1:0] res_val,
    output logic [WIDTH-1:0] cone_reg,
    output logic [WIDTH-1:0] ctwo_reg,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             stk_err,
    output logic [CNT_W-1:0] stk_count
);

    localparam int unsigned      PTR_W   = $clog2(STACK_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_ALU    = 3'b001;
    localparam logic [2:0] OP_CPYIN  = 3'b010;
    localparam logic [2:0] OP_CPYOUT = 3'b011;
    localparam logic [2:0] OP_LOAD   = 3'b100;
    localparam logic [2:0] OP_SWAP   = 3'b101;
    localparam logic [2:0] OP_PUSH   = 3'b110;
    localparam logic [2:0] OP_POP    = 3'b111;

    logic [WIDTH-1:0] r_regs  [NREGS];
    logic [WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_err_set;
    logic [PTR_W-1:0] w_push_idx;
    logic [PTR_W-1:0] w_pop_idx;

    // Stack status and the legality of this cycle's stack op.
    always_comb begin
        w_full     = (r_count == DEPTH_C);
        w_empty    = (r_count == '0);
        w_push_ok  = op_valid && (op == OP_PUSH) && !w_full;
        w_err_set  = op_valid && (((op == OP_PUSH) && w_full) ||
                                  ((op == OP_POP)  && w_empty));
        w_push_idx = r_count[PTR_W-1:0];
        w_pop_idx  = PTR_W'(r_count - CNT_W'(1));
    end

    // Registers, res, stack count and sticky error; reset wins over everything.
    always_ff @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
            r_res   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            // A new error beats a simultaneous clear.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
            if (op_valid) begin
                case (op)
                    OP_NOP:    ;
                    OP_ALU:    r_res <= write_data;
                    OP_CPYIN:  r_res <= r_regs[reg_sel];
                    OP_CPYOUT: r_regs[reg_sel] <= r_res;
                    OP_LOAD:   r_regs[reg_sel] <= write_data;
                    OP_SWAP: begin
                        r_regs[reg_sel] <= r_res;
                        r_res           <= r_regs[reg_sel];
                    end
                    OP_PUSH: begin
                        if (!w_full) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    OP_POP: begin
                        if (!w_empty) begin
                            r_res   <= r_stack[w_pop_idx];
                            r_count <= r_count - CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stack storage is never cleared; entries above count are unreachable.
    always_ff @(negedge clk) begin
        if (!reset && w_push_ok) begin
            r_stack[w_push_idx] <= r_res;
        end
    end

    // Outputs straight from current state.
    always_comb begin
        reg_val   = r_regs[reg_sel];
        res_val   = r_res;
        cone_reg  = r_regs[NREGS-2];
        ctwo_reg  = r_regs[NREGS-1];
        stk_empty = w_empty;
        stk_full  = w_full;
        stk_err   = r_err;
        stk_count = r_count;
    end

endmodule

// File: tb/tb_acc_register_file.sv
// Directed + scoreboard bench for acc_register_file (default and small configs).
module tb_acc_register_file;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: WIDTH=16, NREGS=8, STACK_DEPTH=4
    logic        reset = 1'b0, op_valid = 1'b0, err_clr = 1'b0;
    logic [2:0]  op = 3'b000, reg_sel = 3'd0;
    logic [15:0] write_data = 16'h0;
    logic [15:0] reg_val, res_val, cone_reg, ctwo_reg;
    logic        stk_empty, stk_full, stk_err;
    logic [2:0]  stk_count;

    acc_register_file dut_a (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .reg_sel(reg_sel),
        .write_data(write_data), .err_clr(err_clr), .reg_val(reg_val), .res_val(res_val),
        .cone_reg(cone_reg), .ctwo_reg(ctwo_reg), .stk_empty(stk_empty), .stk_full(stk_full),
        .stk_err(stk_err), .stk_count(stk_count)
    );

    // Small configuration: WIDTH=8, NREGS=16, STACK_DEPTH=2
    logic        b_reset = 1'b0, b_op_valid = 1'b0, b_err_clr = 1'b0;
    logic [2:0]  b_op = 3'b000;
    logic [3:0]  b_reg_sel = 4'd0;
    logic [7:0]  b_write_data = 8'h0;
    logic [7:0]  b_reg_val, b_res_val, b_cone_reg, b_ctwo_reg;
    logic        b_stk_empty, b_stk_full, b_stk_err;
    logic [1:0]  b_stk_count;

    acc_register_file #(.WIDTH(8), .NREGS(16), .STACK_DEPTH(2)) dut_b (
        .clk(clk), .reset(b_reset), .op_valid(b_op_valid), .op(b_op), .reg_sel(b_reg_sel),
        .write_data(b_write_data), .err_clr(b_err_clr), .reg_val(b_reg_val), .res_val(b_res_val),
        .cone_reg(b_cone_reg), .ctwo_reg(b_ctwo_reg), .stk_empty(b_stk_empty), .stk_full(b_stk_full),
        .stk_err(b_stk_err), .stk_count(b_stk_count)
    );

    localparam logic [2:0] NOP = 3'd0, ALU = 3'd1, CPYIN = 3'd2, CPYOUT = 3'd3,
                           LOAD = 3'd4, SWAP = 3'd5, PUSH = 3'd6, POP = 3'd7;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] reg_v;
        logic [15:0] res_v;
        logic [15:0] cone;
        logic [15:0] ctwo;
        logic        empty;
        logic        full;
        logic        err;
        logic [2:0]  count;
    } exp_t;

    exp_t exp_q[$];

    // Reference model of the default configuration
    logic [15:0] m_regs [8];
    logic [15:0] m_res = 16'h0;
    logic [15:0] m_stk[$];
    logic        m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_apply(input logic v, input logic [2:0] o, input logic [2:0] s,
                               input logic [15:0] wd, input logic clr, input logic rst);
        logic [15:0] tmp;
        logic        nerr;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
            m_res = 16'h0;
            m_stk.delete();
            m_err = 1'b0;
        end else begin
            nerr = clr ? 1'b0 : m_err;
            if (v) begin
                case (o)
                    ALU:    m_res = wd;
                    CPYIN:  m_res = m_regs[s];
                    CPYOUT: m_regs[s] = m_res;
                    LOAD:   m_regs[s] = wd;
                    SWAP: begin tmp = m_res; m_res = m_regs[s]; m_regs[s] = tmp; end
                    PUSH:   if (m_stk.size() < 4) m_stk.push_back(m_res); else nerr = 1'b1;
                    POP:    if (m_stk.size() > 0) m_res = m_stk.pop_back(); else nerr = 1'b1;
                    default: ;
                endcase
            end
            m_err = nerr;
        end
    endtask

    // Drive one op on dut_a, queue the model's expectation, compare after the falling edge.
    task automatic step(input logic v, input logic [2:0] o, input logic [2:0] s,
                        input logic [15:0] wd, input logic clr, input logic rst);
        exp_t e;
        op_valid = v; op = o; reg_sel = s; write_data = wd; err_clr = clr; reset = rst;
        model_apply(v, o, s, wd, clr, rst);
        e.reg_v = m_regs[s];
        e.res_v = m_res;
        e.cone  = m_regs[6];
        e.ctwo  = m_regs[7];
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == 4);
        e.err   = m_err;
        e.count = 3'(m_stk.size());
        exp_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        if (exp_q.size() == 0) begin
            check("sb_queue_empty", 32'(0), 32'(1));
        end else begin
            e = exp_q.pop_front();
            check("sb_reg_val",   32'(reg_val),   32'(e.reg_v));
            check("sb_res_val",   32'(res_val),   32'(e.res_v));
            check("sb_cone_reg",  32'(cone_reg),  32'(e.cone));
            check("sb_ctwo_reg",  32'(ctwo_reg),  32'(e.ctwo));
            check("sb_stk_empty", 32'(stk_empty), 32'(e.empty));
            check("sb_stk_full",  32'(stk_full),  32'(e.full));
            check("sb_stk_err",   32'(stk_err),   32'(e.err));
            check("sb_stk_count", 32'(stk_count), 32'(e.count));
        end
    endtask

    task automatic b_step(input logic [2:0] o, input logic [3:0] s, input logic [7:0] wd,
                          input logic rst);
        b_op_valid = 1'b1; b_op = o; b_reg_sel = s; b_write_data = wd; b_reset = rst;
        b_err_clr = 1'b0;
        @(negedge clk);
        @(posedge clk);
        b_op_valid = 1'b0; b_reset = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;

        // Reset state
        step(1, NOP, 3'd0, 16'h0, 0, 1);
        check("rst_reg_val", 32'(reg_val), 32'h0);
        check("rst_res_val", 32'(res_val), 32'h0);
        check("rst_cone", 32'(cone_reg), 32'h0);
        check("rst_ctwo", 32'(ctwo_reg), 32'h0);
        check("rst_empty", 32'(stk_empty), 32'h1);
        check("rst_full", 32'(stk_full), 32'h0);
        check("rst_err", 32'(stk_err), 32'h0);
        check("rst_count", 32'(stk_count), 32'h0);

        // LOAD then CPYIN
        step(1, LOAD, 3'd3, 16'h1234, 0, 0);
        step(1, CPYIN, 3'd3, 16'h0, 0, 0);
        check("cpyin_res", 32'(res_val), 32'h1234);
        check("cpyin_reg", 32'(reg_val), 32'h1234);

        // SWAP uses pre-edge values
        step(1, ALU, 3'd0, 16'hAAAA, 0, 0);
        step(1, LOAD, 3'd6, 16'h5555, 0, 0);
        step(1, SWAP, 3'd6, 16'h0, 0, 0);
        check("swap_res", 32'(res_val), 32'h5555);
        check("swap_cone", 32'(cone_reg), 32'hAAAA);

        // Fill the stack, overflow, then drain in LIFO order
        for (int k = 1; k <= 4; k++) begin
            step(1, ALU, 3'd0, 16'(k), 0, 0);
            step(1, PUSH, 3'd0, 16'h0, 0, 0);
        end
        check("full_flag", 32'(stk_full), 32'h1);
        check("full_count", 32'(stk_count), 32'h4);
        step(1, PUSH, 3'd0, 16'h0, 0, 0);
        check("ovf_count", 32'(stk_count), 32'h4);
        check("ovf_err", 32'(stk_err), 32'h1);
        step(0, NOP, 3'd0, 16'h0, 1, 0);
        for (int k = 4; k >= 1; k--) begin
            step(1, POP, 3'd0, 16'h0, 0, 0);
            check("pop_res", 32'(res_val), 32'(k));
        end
        check("drain_empty", 32'(stk_empty), 32'h1);

        // Underflow and sticky error
        step(1, ALU, 3'd0, 16'h00FF, 0, 0);
        step(1, POP, 3'd0, 16'h0, 0, 0);
        check("unf_res", 32'(res_val), 32'h00FF);
        check("unf_err", 32'(stk_err), 32'h1);
        step(0, NOP, 3'd0, 16'h0, 0, 0);
        check("err_sticky", 32'(stk_err), 32'h1);
        step(0, NOP, 3'd0, 16'h0, 1, 0);
        check("err_clr", 32'(stk_err), 32'h0);
        step(1, POP, 3'd0, 16'h0, 1, 0);
        check("err_clr_vs_set", 32'(stk_err), 32'h1);
        step(0, NOP, 3'd0, 16'h0, 1, 0);

        // op_valid low is NOP; CPYOUT to the top register
        step(0, ALU, 3'd0, 16'hFFFF, 0, 0);
        check("nop_res", 32'(res_val), 32'h00FF);
        step(1, ALU, 3'd0, 16'hBEEF, 0, 0);
        step(1, CPYOUT, 3'd7, 16'h0, 0, 0);
        check("cpyout_ctwo", 32'(ctwo_reg), 32'hBEEF);

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 16'($urandom), 1'($urandom_range(0, 3) == 0), 0);
        end

        // Reset mid-sequence with PUSH pending
        step(1, NOP, 3'd0, 16'h0, 0, 1);
        step(1, POP, 3'd0, 16'h0, 0, 0);
        step(1, ALU, 3'd0, 16'h0011, 0, 0);
        step(1, PUSH, 3'd0, 16'h0, 0, 0);
        step(1, PUSH, 3'd0, 16'h0, 0, 0);
        check("pre_rst_count", 32'(stk_count), 32'h2);
        step(1, PUSH, 3'd0, 16'h0, 0, 1);
        check("mid_rst_count", 32'(stk_count), 32'h0);
        check("mid_rst_res", 32'(res_val), 32'h0);
        check("mid_rst_err", 32'(stk_err), 32'h0);
        step(1, POP, 3'd0, 16'h0, 0, 0);
        check("mid_rst_nopush", 32'(stk_err), 32'h1);

        // Small configuration
        b_step(NOP, 4'd0, 8'h0, 1);
        check("b_rst_empty", 32'(b_stk_empty), 32'h1);
        check("b_rst_res", 32'(b_res_val), 32'h0);
        b_step(LOAD, 4'd15, 8'h77, 0);
        check("b_ctwo", 32'(b_ctwo_reg), 32'h77);
        b_step(LOAD, 4'd14, 8'h66, 0);
        check("b_cone", 32'(b_cone_reg), 32'h66);
        b_step(ALU, 4'd0, 8'h5A, 0);
        b_step(PUSH, 4'd0, 8'h0, 0);
        b_step(ALU, 4'd0, 8'h3C, 0);
        b_step(PUSH, 4'd0, 8'h0, 0);
        check("b_full", 32'(b_stk_full), 32'h1);
        check("b_count", 32'(b_stk_count), 32'h2);
        b_step(PUSH, 4'd0, 8'h0, 0);
        check("b_ovf_err", 32'(b_stk_err), 32'h1);
        b_step(POP, 4'd0, 8'h0, 0);
        check("b_pop_res", 32'(b_res_val), 32'h3C);
        b_step(PUSH, 4'd0, 8'h0, 0);
        b_step(PUSH, 4'd0, 8'h0, 1);
        check("b_rst_count", 32'(b_stk_count), 32'h0);
        check("b_rst_res2", 32'(b_res_val), 32'h0);
        check("b_rst_err", 32'(b_stk_err), 32'h0);
        check("b_rst_cone", 32'(b_cone_reg), 32'h0);
        b_step(POP, 4'd0, 8'h0, 0);
        check("b_nopush", 32'(b_stk_err), 32'h1);
        check("b_nopush_res", 32'(b_res_val), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
